// File: rtl/prog_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem_pkg
// Description : Shared types and constants for the prog_mem instruction
//               store: state encoding, NOP word and instruction width.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_mem_pkg;

  localparam int INSTR_W = 32;

  // Conditional instruction, op 0, condition never true: the CPU executes
  // it as a no-op.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0800_0000;

  // Top-level store state
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_RUN  = 2'd2;
  localparam state_t ST_ERR  = 2'd3;

endpackage : prog_mem_pkg
`default_nettype wire

// File: rtl/prog_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem_if
// Description : Host-load stream and CPU fetch bundle of prog_mem.
//               master : host/CPU side (drives load stream, run, next_addr)
//               slave  : prog_mem side
// Signals     : load_start, load_valid, load_data[31:0], load_last,
//               load_ready, run, next_addr[31:0], instruction[31:0],
//               cpu_en, prog_len[AW:0], prog_end, load_err,
//               csum[31:0] (only with PROG_MEM_CSUM_EN)
// Options     : PROG_MEM_CSUM_EN adds the csum signal
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_mem_if
  import prog_mem_pkg::*;
#(
  parameter int AW = 8
);
  logic               load_start;
  logic               load_valid;
  logic [INSTR_W-1:0] load_data;
  logic               load_last;
  logic               load_ready;
  logic               run;
  logic [31:0]        next_addr;
  logic [INSTR_W-1:0] instruction;
  logic               cpu_en;
  logic [AW:0]        prog_len;
  logic               prog_end;
  logic               load_err;
`ifdef PROG_MEM_CSUM_EN
  logic [INSTR_W-1:0] csum;
`endif

  modport master (
    output load_start, load_valid, load_data, load_last, run, next_addr,
    input  load_ready, instruction, cpu_en, prog_len, prog_end, load_err
`ifdef PROG_MEM_CSUM_EN
    , input csum
`endif
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, run, next_addr,
    output load_ready, instruction, cpu_en, prog_len, prog_end, load_err
`ifdef PROG_MEM_CSUM_EN
    , output csum
`endif
  );

endinterface : prog_mem_if
`default_nettype wire

// File: rtl/prog_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem_loader
// Description : Program load engine. Accepts the host word stream, produces
//               memory write strobes, tracks the write pointer, detects
//               overflow and (optionally) verifies a trailing checksum.
// Ports       : clk, rst_n          - clock, async active-low reset
//               i_load_start       - restart pulse (wins over a handshake)
//               i_load_valid/data/last, o_load_ready - host stream
//               o_wr_en/addr/data  - memory write port
//               o_done, o_len      - load completed, stored word count
//               o_err              - load failed (overflow / bad checksum)
//               o_csum             - running sum (PROG_MEM_CSUM_EN only)
// Options     : PROG_MEM_CSUM_EN - final word is a checksum, not stored
// Revision    : 1.0 - initial release
// ============================================================================
module prog_mem_loader
  import prog_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load_start,
  input  logic               i_load_valid,
  input  logic [INSTR_W-1:0] i_load_data,
  input  logic               i_load_last,
  output logic               o_load_ready,
  output logic               o_wr_en,
  output logic [AW-1:0]      o_wr_addr,
  output logic [INSTR_W-1:0] o_wr_data,
  output logic               o_done,
  output logic               o_err,
  output logic [AW:0]        o_len
`ifdef PROG_MEM_CSUM_EN
  , output logic [INSTR_W-1:0] o_csum
`endif
);

  localparam logic [0:0] L_IDLE = 1'b0;
  localparam logic [0:0] L_BUSY = 1'b1;

  localparam logic [AW:0] c_wptr_top = (AW+1)'(DEPTH - 1);

  logic [0:0] r_lstate;
  logic [AW:0] r_wptr;
  logic       w_hs;
  logic       w_last_hs;
  logic       w_ovf;
  logic       w_sum_ok;

  // The pointer never reaches DEPTH while busy: a non-final word at
  // DEPTH-1 ends the load as an overflow, so busy alone implies wptr<DEPTH.
  assign o_load_ready = (r_lstate == L_BUSY);

  // A word offered alongside load_start is dropped.
  assign w_hs      = i_load_valid & o_load_ready & ~i_load_start;
  assign w_last_hs = w_hs & i_load_last;
  assign w_ovf     = w_hs & ~i_load_last & (r_wptr == c_wptr_top);

  assign o_wr_addr = r_wptr[AW-1:0];
  assign o_wr_data = i_load_data;

`ifdef PROG_MEM_CSUM_EN
  logic [INSTR_W-1:0] r_csum;

  assign o_csum   = r_csum;
  assign w_sum_ok = (r_csum == i_load_data);
  assign o_wr_en  = w_hs & ~i_load_last;
  assign o_len    = r_wptr;
`else
  assign w_sum_ok = 1'b1;
  assign o_wr_en  = w_hs;
  assign o_len    = r_wptr + 1'b1;
`endif

  assign o_done = w_last_hs & w_sum_ok;
  assign o_err  = w_ovf | (w_last_hs & ~w_sum_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lstate <= L_IDLE;
      r_wptr   <= '0;
    end else if (i_load_start) begin
      r_lstate <= L_BUSY;
      r_wptr   <= '0;
    end else if (r_lstate == L_BUSY) begin
      if (w_hs) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (o_done || o_err) begin
        r_lstate <= L_IDLE;
      end
    end
  end

`ifdef PROG_MEM_CSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if (i_load_start) begin
      r_csum <= '0;
    end else if (w_hs && !i_load_last) begin
      r_csum <= r_csum + i_load_data;
    end
  end
`endif

endmodule : prog_mem_loader
`default_nettype wire

// File: rtl/prog_mem.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem
// Description : Instruction store between the program loader/host port and
//               the CPU fetch pins. Holds the word array, the IDLE/LOAD/
//               RUN/ERR control and the zero-latency fetch mux.
// Ports       : clk    - clock
//               rst_n  - asynchronous active-low reset
//               bus    - prog_mem_if.slave (load stream, run, fetch,
//                        cpu_en, prog_len, prog_end, load_err, csum)
// Options     : PROG_MEM_CSUM_EN - checksum-terminated loads, csum output
// Revision    : 1.0 - initial release
// ============================================================================
module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic       clk,
  input logic       rst_n,
  prog_mem_if.slave bus
);

  logic [INSTR_W-1:0] r_mem [DEPTH];

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_cpu_en;
  logic [AW:0]        r_prog_len;
  logic               r_prog_end;
  logic               r_load_err;

  logic               w_wr_en;
  logic [AW-1:0]      w_wr_addr;
  logic [INSTR_W-1:0] w_wr_data;
  logic               w_ld_done;
  logic               w_ld_err;
  logic [AW:0]        w_ld_len;
  logic [31:0]        w_len_ext;
  logic               w_in_range;

  prog_mem_loader #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_loader (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load_start (bus.load_start),
    .i_load_valid (bus.load_valid),
    .i_load_data  (bus.load_data),
    .i_load_last  (bus.load_last),
    .o_load_ready (bus.load_ready),
    .o_wr_en      (w_wr_en),
    .o_wr_addr    (w_wr_addr),
    .o_wr_data    (w_wr_data),
    .o_done       (w_ld_done),
    .o_err        (w_ld_err),
    .o_len        (w_ld_len)
`ifdef PROG_MEM_CSUM_EN
    , .o_csum     (bus.csum)
`endif
  );

  // Storage is intentionally not reset; prog_len gates what is visible.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= w_wr_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.load_start) begin
      w_state_nxt = ST_LOAD;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.run && (r_prog_len != '0)) w_state_nxt = ST_RUN;
        ST_LOAD: begin
          if (w_ld_err)       w_state_nxt = ST_ERR;
          else if (w_ld_done) w_state_nxt = ST_IDLE;
        end
        ST_RUN:  if (!bus.run) w_state_nxt = ST_IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Full 32-bit compare: addresses above the array alias nothing.
  assign w_len_ext  = 32'(r_prog_len);
  assign w_in_range = (bus.next_addr < w_len_ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cpu_en   <= 1'b0;
      r_prog_len <= '0;
      r_prog_end <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cpu_en <= (w_state_nxt == ST_RUN);
      if (bus.load_start) begin
        // Any new load invalidates the previous program.
        r_prog_len <= '0;
        r_prog_end <= 1'b0;
        r_load_err <= 1'b0;
      end else begin
        if (w_ld_done) begin
          r_prog_len <= w_ld_len;
        end
        if (w_ld_err) begin
          r_prog_len <= '0;
          r_load_err <= 1'b1;
        end
        if ((r_state == ST_RUN) && !w_in_range) begin
          r_prog_end <= 1'b1;
        end
      end
    end
  end

  assign bus.instruction = ((r_state == ST_RUN) && w_in_range)
                           ? r_mem[bus.next_addr[AW-1:0]] : NOP_INSTR;
  assign bus.cpu_en      = r_cpu_en;
  assign bus.prog_len    = r_prog_len;
  assign bus.prog_end    = r_prog_end;
  assign bus.load_err    = r_load_err;

endmodule : prog_mem
`default_nettype wire
